// File: rtl/i_fetcher.sv
// i_fetcher: instruction fetch sequencer.
// Loop: look up the I-cache, refill from memory on a miss, then push the instruction into the IQ.
// Optional feature: define FETCH_JAL_PRED_EN to follow JAL targets at fetch time.
// With FETCH_JAL_PRED_EN set, the fetcher predicts a JAL as taken and raises iq_pred_taken.
`timescale 1ns/1ps
module i_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  input  logic        icache_hit,
  input  logic [31:0] icache_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        cache_wr_en,
  output logic [31:0] cache_wr_pc,
  output logic [31:0] cache_wr_inst,
  input  logic        iq_full,
  output logic        iq_valid,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_inst,
  output logic        iq_pred_taken,
  input  logic        jump_en,
  input  logic [31:0] jump_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_REFILL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        cache_wr_en_q, cache_wr_en_d;
  logic [31:0] cache_wr_pc_q, cache_wr_pc_d;
  logic [31:0] cache_wr_inst_q, cache_wr_inst_d;
  logic        iq_valid_q, iq_valid_d;
  logic [31:0] iq_pc_q, iq_pc_d;
  logic [31:0] iq_inst_q, iq_inst_d;

  // The instruction being pushed comes from memory during a refill, otherwise from the cache
  logic [31:0] push_inst;
  logic [31:0] npc;
  logic        push_pred;

  assign push_inst = (state_q == S_REFILL) ? mem_data : icache_inst;

`ifdef FETCH_JAL_PRED_EN
  logic iq_pred_q, iq_pred_d;

  function automatic logic is_jal(input logic [31:0] inst);
    return inst[6:0] == 7'b1101111;
  endfunction

  function automatic logic signed [31:0] jal_offset(input logic [31:0] inst);
    return $signed({{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0});
  endfunction

  // Follow a JAL immediately; everything else falls through to pc+4
  always_comb begin
    push_pred = is_jal(push_inst);
    npc       = push_pred ? pc_q + $unsigned(jal_offset(push_inst)) : pc_q + 32'd4;
  end

  assign iq_pred_taken = iq_pred_q;
`else
  assign push_pred     = 1'b0;
  assign npc           = pc_q + 32'd4;
  assign iq_pred_taken = 1'b0;
`endif

  // State register; a low rdy_in freezes the FSM
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state_q <= S_REQ;
    else if (rdy_in) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:    if (!jump_en && !iq_full) state_d = S_WAIT;
      S_WAIT:   state_d = (jump_en || icache_hit) ? S_REQ : S_REFILL;
      S_REFILL: if (mem_done) state_d = S_REQ;
      default:  state_d = S_REQ;
    endcase
  end

  // Output and PC next-state values; level outputs hold, pulses default low
  always_comb begin
    pc_d            = pc_q;
    pend_d          = pend_q;
    pend_pc_d       = pend_pc_q;
    fetch_valid_d   = 1'b0;
    fetch_pc_d      = fetch_pc_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    cache_wr_en_d   = 1'b0;
    cache_wr_pc_d   = cache_wr_pc_q;
    cache_wr_inst_d = cache_wr_inst_q;
    iq_valid_d      = 1'b0;
    iq_pc_d         = iq_pc_q;
    iq_inst_d       = iq_inst_q;
`ifdef FETCH_JAL_PRED_EN
    iq_pred_d       = iq_pred_q;
`endif
    case (state_q)
      S_REQ: begin
        if (jump_en) begin
          pc_d = jump_pc;
        end else if (!iq_full) begin
          fetch_valid_d = 1'b1;
          fetch_pc_d    = pc_q;
        end
      end
      S_WAIT: begin
        if (jump_en) begin
          pc_d = jump_pc;
        end else if (icache_hit) begin
          iq_valid_d = 1'b1;
          iq_pc_d    = pc_q;
          iq_inst_d  = push_inst;
`ifdef FETCH_JAL_PRED_EN
          iq_pred_d  = push_pred;
`endif
          pc_d       = npc;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      S_REFILL: begin
        if (mem_done) begin
          mem_req_d       = 1'b0;
          cache_wr_en_d   = 1'b1;
          cache_wr_pc_d   = pc_q;
          cache_wr_inst_d = mem_data;
          pend_d          = 1'b0;
          // A redirect seen during the refill (or on this very edge) drops the push
          if (jump_en) begin
            pc_d = jump_pc;
          end else if (pend_q) begin
            pc_d = pend_pc_q;
          end else begin
            iq_valid_d = 1'b1;
            iq_pc_d    = pc_q;
            iq_inst_d  = push_inst;
`ifdef FETCH_JAL_PRED_EN
            iq_pred_d  = push_pred;
`endif
            pc_d       = npc;
          end
        end else if (jump_en) begin
          pend_d    = 1'b1;
          pend_pc_d = jump_pc;
        end
      end
      default: ;
    endcase
  end

  // PC, pending redirect and registered outputs; all held while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_q            <= RESET_PC;
      pend_q          <= 1'b0;
      pend_pc_q       <= 32'h0;
      fetch_valid_q   <= 1'b0;
      fetch_pc_q      <= RESET_PC;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= 32'h0;
      cache_wr_en_q   <= 1'b0;
      cache_wr_pc_q   <= 32'h0;
      cache_wr_inst_q <= 32'h0;
      iq_valid_q      <= 1'b0;
      iq_pc_q         <= 32'h0;
      iq_inst_q       <= 32'h0;
`ifdef FETCH_JAL_PRED_EN
      iq_pred_q       <= 1'b0;
`endif
    end else if (rdy_in) begin
      pc_q            <= pc_d;
      pend_q          <= pend_d;
      pend_pc_q       <= pend_pc_d;
      fetch_valid_q   <= fetch_valid_d;
      fetch_pc_q      <= fetch_pc_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      cache_wr_en_q   <= cache_wr_en_d;
      cache_wr_pc_q   <= cache_wr_pc_d;
      cache_wr_inst_q <= cache_wr_inst_d;
      iq_valid_q      <= iq_valid_d;
      iq_pc_q         <= iq_pc_d;
      iq_inst_q       <= iq_inst_d;
`ifdef FETCH_JAL_PRED_EN
      iq_pred_q       <= iq_pred_d;
`endif
    end
  end

  assign fetch_valid   = fetch_valid_q;
  assign fetch_pc      = fetch_pc_q;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign cache_wr_en   = cache_wr_en_q;
  assign cache_wr_pc   = cache_wr_pc_q;
  assign cache_wr_inst = cache_wr_inst_q;
  assign iq_valid      = iq_valid_q;
  assign iq_pc         = iq_pc_q;
  assign iq_inst       = iq_inst_q;

endmodule

// File: tb/tb_i_fetcher.sv
// tb_i_fetcher: directed and randomized checks of i_fetcher against a PC-sequence model.
`timescale 1ns/1ps
module tb_i_fetcher;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        icache_hit;
  logic [31:0] icache_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        cache_wr_en;
  logic [31:0] cache_wr_pc, cache_wr_inst;
  logic        iq_full, iq_valid;
  logic [31:0] iq_pc, iq_inst;
  logic        iq_pred_taken;
  logic        jump_en;
  logic [31:0] jump_pc;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_pc;

  i_fetcher #(.RESET_PC(RST_PC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .icache_hit(icache_hit), .icache_inst(icache_inst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_data(mem_data),
    .cache_wr_en(cache_wr_en), .cache_wr_pc(cache_wr_pc), .cache_wr_inst(cache_wr_inst),
    .iq_full(iq_full), .iq_valid(iq_valid), .iq_pc(iq_pc), .iq_inst(iq_inst),
    .iq_pred_taken(iq_pred_taken),
    .jump_en(jump_en), .jump_pc(jump_pc)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference rule for the PC after a pushed instruction
  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] inst);
    int off;
`ifdef FETCH_JAL_PRED_EN
    if (inst[6:0] == 7'h6F) begin
      off = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096;
      if (inst[31]) off = off - (1 << 20);
      return pc + 32'(off);
    end
`endif
    off = 4;
    return pc + 32'(off);
  endfunction

  function automatic logic model_pred(input logic [31:0] inst);
`ifdef FETCH_JAL_PRED_EN
    return inst[6:0] == 7'h6F;
`else
    return 1'b0 & inst[0];
`endif
  endfunction

  // Redirect while in S_REQ
  task automatic jump_req(input logic [31:0] tgt);
    jump_en = 1'b1; jump_pc = tgt;
    tick();
    jump_en = 1'b0;
    chk("jreq_fetch_valid", fetch_valid, 0);
    chk("jreq_iq_valid", iq_valid, 0);
    model_pc = tgt;
  endtask

  // Redirect arriving in S_WAIT: no push, no refill
  task automatic jump_wait(input logic [31:0] tgt);
    tick();
    chk("jw_fetch_valid", fetch_valid, 1);
    chk("jw_fetch_pc", fetch_pc, model_pc);
    jump_en = 1'b1; jump_pc = tgt; icache_hit = $urandom_range(0, 1);
    tick();
    jump_en = 1'b0; icache_hit = 1'b0;
    chk("jw_iq_valid", iq_valid, 0);
    chk("jw_mem_req", mem_req, 0);
    model_pc = tgt;
  endtask

  task automatic full_stall(input int n);
    iq_full = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("full_fetch_valid", fetch_valid, 0);
    end
    iq_full = 1'b0;
  endtask

  // One fetch starting in S_REQ. lat: refill cycles (miss only); jcyc: refill cycle
  // carrying a redirect (0 = none); sloc/sn: where and how long rdy_in drops
  // (1 = in S_WAIT, 2 = at refill start, 3 = right after completion).
  task automatic fetch(input bit hit, input logic [31:0] inst, input int lat,
                       input int jcyc, input logic [31:0] jpc, input int sloc, input int sn);
    bit jumped;
    tick();
    chk("fetch_valid", fetch_valid, 1);
    chk("fetch_pc", fetch_pc, model_pc);
    chk("iq_valid_idle", iq_valid, 0);
    if (sloc == 1) begin
      rdy_in = 1'b0; jump_en = 1'b1; jump_pc = ~model_pc & 32'hFFFF_FFFC; icache_hit = 1'b1;
      for (int i = 0; i < sn; i++) begin
        tick();
        chk("stw_fetch_valid", fetch_valid, 1);
        chk("stw_fetch_pc", fetch_pc, model_pc);
        chk("stw_mem_req", mem_req, 0);
        chk("stw_iq_valid", iq_valid, 0);
      end
      rdy_in = 1'b1; jump_en = 1'b0;
    end
    icache_hit = hit; icache_inst = inst;
    tick();
    icache_hit = 1'b0; icache_inst = $urandom;
    chk("fetch_valid_pulse", fetch_valid, 0);
    jumped = 1'b0;
    if (hit) begin
      chk("hit_iq_valid", iq_valid, 1);
      chk("hit_iq_pc", iq_pc, model_pc);
      chk("hit_iq_inst", iq_inst, inst);
      chk("hit_pred", iq_pred_taken, model_pred(inst));
      chk("hit_mem_req", mem_req, 0);
    end else begin
      chk("miss_mem_req", mem_req, 1);
      chk("miss_mem_addr", mem_addr, model_pc);
      chk("miss_iq_valid", iq_valid, 0);
      if (sloc == 2) begin
        rdy_in = 1'b0; mem_done = 1'b1; mem_data = $urandom; jump_en = 1'b1; jump_pc = 32'hDEAD_BEE0;
        for (int i = 0; i < sn; i++) begin
          tick();
          chk("str_mem_req", mem_req, 1);
          chk("str_mem_addr", mem_addr, model_pc);
          chk("str_cache_wr_en", cache_wr_en, 0);
        end
        rdy_in = 1'b1; mem_done = 1'b0; jump_en = 1'b0;
      end
      for (int c = 1; c <= lat; c++) begin
        if (c == jcyc) begin jump_en = 1'b1; jump_pc = jpc; jumped = 1'b1; end
        if (c == lat) begin mem_done = 1'b1; mem_data = inst; end
        tick();
        jump_en = 1'b0; mem_done = 1'b0;
        if (c < lat) begin
          chk("refill_mem_req", mem_req, 1);
          chk("refill_mem_addr", mem_addr, model_pc);
          chk("refill_wr_en", cache_wr_en, 0);
        end else begin
          chk("done_mem_req", mem_req, 0);
          chk("done_wr_en", cache_wr_en, 1);
          chk("done_wr_pc", cache_wr_pc, model_pc);
          chk("done_wr_inst", cache_wr_inst, inst);
          chk("done_iq_valid", iq_valid, !jumped);
          if (!jumped) begin
            chk("done_iq_pc", iq_pc, model_pc);
            chk("done_iq_inst", iq_inst, inst);
            chk("done_pred", iq_pred_taken, model_pred(inst));
          end
        end
      end
    end
    if (sloc == 3) begin
      rdy_in = 1'b0; jump_en = 1'b1; jump_pc = 32'h0000_0F00;
      for (int i = 0; i < sn; i++) begin
        tick();
        chk("stp_iq_valid", iq_valid, !jumped);
        chk("stp_wr_en", cache_wr_en, !hit);
        chk("stp_fetch_valid", fetch_valid, 0);
      end
      rdy_in = 1'b1; jump_en = 1'b0;
    end
    model_pc = jumped ? jpc : model_npc(model_pc, inst);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) == 0) v[6:0] = 7'h6F;
    return v;
  endfunction

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; icache_hit = 1'b0; icache_inst = 32'h0;
    mem_done = 1'b0; mem_data = 32'h0; iq_full = 1'b0; jump_en = 1'b0; jump_pc = 32'h0;
    model_pc = RST_PC;
    #1;
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_pc", fetch_pc, RST_PC);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_en", cache_wr_en, 0);
    chk("rst_iq_valid", iq_valid, 0);
    chk("rst_iq_pc", iq_pc, 0);
    chk("rst_pred", iq_pred_taken, 0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Straight-line hits from reset
    for (int i = 0; i < 3; i++) fetch(1'b1, 32'h0000_0013 + 32'(i << 7), 0, 0, 0, 0, 0);

    // Miss at 0x10, five-cycle refill
    jump_req(32'h10);
    fetch(1'b0, 32'h0050_0093, 5, 0, 0, 0, 0);
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 0, 0);
    chk("after_refill_iq_pc", iq_pc, 32'h14);

    // Redirect during refill cycle 2 at 0x20
    jump_req(32'h20);
    fetch(1'b0, 32'h1234_5678, 4, 2, 32'h100, 0, 0);
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 0, 0);
    chk("after_pend_iq_pc", iq_pc, 32'h100);

    // Redirect on the same edge as mem_done
    fetch(1'b0, 32'hCAFE_0013, 3, 3, 32'h200, 0, 0);
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 0, 0);
    chk("same_edge_iq_pc", iq_pc, 32'h200);

    // IQ full for three cycles
    full_stall(3);
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 0, 0);

    // JAL +16 at 0x40
    jump_req(32'h40);
    fetch(1'b1, 32'h0100_006F, 0, 0, 0, 0, 0);
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 0, 0);
`ifdef FETCH_JAL_PRED_EN
    chk("jal_target_iq_pc", iq_pc, 32'h50);
`else
    chk("jal_target_iq_pc", iq_pc, 32'h44);
`endif

    // PC wrap
    jump_req(32'hFFFF_FFFC);
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 0, 0);
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 0, 0);
    chk("wrap_iq_pc", iq_pc, 32'h0);

    // Redirect in S_WAIT, then ready stalls at each point
    jump_wait(32'h300);
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 1, 4);
    fetch(1'b0, 32'h0000_0093, 3, 0, 0, 2, 3);
    fetch(1'b1, 32'h0000_0113, 0, 0, 0, 3, 2);
    fetch(1'b0, 32'h0000_0193, 2, 0, 0, 3, 2);

    // Randomized mix
    for (int it = 0; it < 60; it++) begin
      int kind, lat, jc, sl;
      kind = $urandom_range(0, 5);
      lat  = $urandom_range(1, 6);
      jc   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, lat) : 0;
      sl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      case (kind)
        0, 1: fetch(1'b1, rand_inst(), 0, 0, 0, sl, $urandom_range(1, 3));
        2:    fetch(1'b0, rand_inst(), lat, jc, $urandom & 32'hFFFF_FFFC, sl, $urandom_range(1, 3));
        3:    jump_req($urandom & 32'hFFFF_FFFC);
        4:    jump_wait($urandom & 32'hFFFF_FFFC);
        default: full_stall($urandom_range(1, 4));
      endcase
    end

    // Ready stall in S_WAIT, then reset in the middle of a later refill
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 1, 4);
    tick();
    chk("pre_rst_fetch_valid", fetch_valid, 1);
    icache_hit = 1'b0;
    tick();
    chk("pre_rst_mem_req", mem_req, 1);
    repeat (2) tick();
    #3;
    rst_in = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_fetch_pc", fetch_pc, RST_PC);
    chk("midrst_fetch_valid", fetch_valid, 0);
    chk("midrst_iq_valid", iq_valid, 0);
    chk("midrst_wr_en", cache_wr_en, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    model_pc = RST_PC;
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 0, 0);
    fetch(1'b1, 32'h0000_0013, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
